mult_sequencer: RTL and testbench
=================================

// Module: mult_sequencer
// PURPOSE
//  - Multi-cycle signed multiplier controller. Runs radix-2 Booth over WIDTH iterations using the external 2*WIDTH-bit product register as accumulator.
//  - Drives that register's write enable, data and reset, and reads its output back each cycle.
//  - Sits between the ALU-side multiply request (ctrl_mult) and the product register. Returns the low WIDTH bits with a one-cycle ready pulse.
// PARAMETERS
//  - WIDTH  32  operand width; product width is 2*WIDTH
//  - CNT_W   5  iteration counter width, $clog2(WIDTH)
// PORTS
//  - clk          in   1        clock; all state updates on rising edge
//  - res          in   1        synchronous, active-high reset
//  - ctrl_mult    in   1        start pulse; operands sampled on this edge
//  - abort        in   1        synchronous cancel of an operation in flight
//  - op_a         in   WIDTH    multiplicand (signed)
//  - op_b         in   WIDTH    multiplier (signed)
//  - product_q    in   2*WIDTH  product register output
//  - product_d    out  2*WIDTH  product register next-value data
//  - product_we   out  1        product register write enable; driven straight from a flop (glitch-free)
//  - product_res  out  1        product register clear
//  - busy         out  1        operation in progress
//  - result_rdy   out  1        one-cycle pulse: result valid
//  - result       out  WIDTH    product_q[WIDTH-1:0], held until next accepted start
//  - result_ovf   out  1        product does not fit in WIDTH signed bits
// BEHAVIOUR
//  - Reset values: busy=0, result_rdy=0, result=0, result_ovf=0, product_we=0, product_d=0, product_res=1 while res is high, state=IDLE.
//  - States:
//      IDLE   --ctrl_mult--> INIT
//      INIT   -------------> ITER
//      ITER   --cnt==WIDTH-1--> DONE
//      DONE   --ctrl_mult--> INIT, else IDLE
//  - IDLE/DONE + ctrl_mult: latch op_a into mcand_r. Load product_d={WIDTH'b0, op_b}, product_we=1, q_prev<=0, cnt<=0.
//  - ITER, one Booth step per cycle on {product_q[0], q_prev}:
//      01: upper += mcand
//      10: upper -= mcand
//      00/11: no change
//      Upper is computed in WIDTH+1 bits (sign-extended), then the WIDTH+1+WIDTH value is arithmetic-shifted right by 1 into product_d.
//      product_we=1; q_prev<=product_q[0]; cnt++.
//  - Latency: ctrl_mult sampled at edge t -> INIT cycle t+1 -> ITER cycles t+2..t+WIDTH+1 -> DONE cycle t+WIDTH+2.
//  - DONE: result_rdy=1 for exactly that cycle. result latched from product_q low half. busy is high INIT..ITER only.
//  - product_we=0 in IDLE and DONE; product register holds its value.
//  - ctrl_mult while busy: ignored, no queueing.
//  - ctrl_mult in DONE cycle: accepted back-to-back; result_rdy still pulses.
//  - abort or res mid-operation: next state IDLE, busy=0, no result_rdy. product_res=1 for one cycle. result keeps its previous value on abort; res clears it.
//  - abort and ctrl_mult in the same IDLE cycle: abort wins; start dropped.
//  - Wrap-around: op_a=most-negative is correct because of the WIDTH+1-bit upper add.
// CONFIGURATION
//  - Macro MULT_OVF_CHECK_EN.
//  - Defined: result_ovf is registered in DONE as ~(&product_q[2W-1:W-1] | ~|product_q[2W-1:W-1]), valid with result_rdy and held with result.
//  - Undefined: result_ovf tied 0, no comparison logic; port list unchanged.
// STRUCTURE
//  - Shared package mult_pkg: state encoding constants (IDLE, INIT, ITER, DONE), WIDTH default, Booth op codes (NOP, ADD, SUB).
//  - Sub-module booth_step: combinational; takes product_q, q_prev, mcand and returns next product_d.
//  - Controller holds the FSM, counter, operand latch and outputs only.
// TESTING
//  - 3 x 4: ctrl_mult at t -> result_rdy at t+34, result=32'd12, ovf=0; busy high for 33 cycles.
//  - -7 x 6: result=32'hFFFFFFD6, ovf=0.
//  - 32'h80000000 x 32'hFFFFFFFF: result=32'h80000000; ovf=1 with macro, 0 without.
//  - 32'h7FFFFFFF x 32'h7FFFFFFF: result=32'h00000001; ovf=1 with macro.
//  - ctrl_mult pulsed again at t+10 with new operands: ignored, first result unchanged. ctrl_mult in DONE cycle starts the second op; next rdy at t+34+34.
//  - abort at t+12: busy=0 and product_res=1 at t+13, no result_rdy, result keeps its prior value. res at t+12: all outputs at reset values.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the Booth multiply sequencer: FSM states, Booth step opcodes, default width.
package mult_pkg;

    localparam int unsigned WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of {current LSB, previous LSB}.
    function automatic booth_op_e booth_decode(input logic q0, input logic q_prev);
        case ({q0, q_prev})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/mult_sequencer_booth_step.sv
// One radix-2 Booth iteration: add/subtract multiplicand into the upper half, then arithmetic shift right.
module booth_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] product_q,
    input  logic               q_prev,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] product_d
);

    logic [WIDTH:0] upper_ext;
    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] upper_sum;

    // One guard bit keeps the most-negative multiplicand from wrapping.
    always_comb begin
        upper_ext = {product_q[2*WIDTH-1], product_q[2*WIDTH-1:WIDTH]};
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (booth_decode(product_q[0], q_prev))
            ADD:     upper_sum = upper_ext + mcand_ext;
            SUB:     upper_sum = upper_ext - mcand_ext;
            default: upper_sum = upper_ext;
        endcase
        product_d = {upper_sum, product_q[WIDTH-1:1]};
    end

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle signed Booth multiplier controller driving an external 2*WIDTH product register.
// Optional overflow flag enabled by defining MULT_OVF_CHECK_EN.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               res,
    input  logic               ctrl_mult,
    input  logic               abort,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [2*WIDTH-1:0] product_q,
    output logic [2*WIDTH-1:0] product_d,
    output logic               product_we,
    output logic               product_res,
    output logic               busy,
    output logic               result_rdy,
    output logic [WIDTH-1:0]   result,
    output logic               result_ovf
);

    localparam int unsigned PW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_prev_q, q_prev_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    load_q, load_d;
    logic             busy_q, busy_d;
    logic             result_rdy_q, result_rdy_d;
    logic             product_we_q, product_we_d;
    logic             product_res_q, product_res_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [PW-1:0]    booth_nxt;
    logic             last_iter_c;
    logic             in_flight_c;

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .product_q (product_q),
        .q_prev    (q_prev_q),
        .mcand     (mcand_q),
        .product_d (booth_nxt)
    );

    assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));
    assign in_flight_c = (state_q == INIT) || (state_q == ITER);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        q_prev_d      = q_prev_q;
        mcand_d       = mcand_q;
        load_d        = load_q;
        result_d      = result_q;

        case (state_q)
            IDLE: if (ctrl_mult) state_d = INIT;
            INIT: state_d = ITER;
            ITER: begin
                q_prev_d = product_q[0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_iter_c) state_d = DONE;
            end
            DONE:    state_d = ctrl_mult ? INIT : IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides any start or completion in the same cycle.
        if (abort) state_d = IDLE;

        if (state_d == INIT) begin
            mcand_d  = op_a;
            load_d   = {WIDTH'(0), op_b};
            q_prev_d = 1'b0;
            cnt_d    = '0;
        end
        if (state_d == DONE) result_d = booth_nxt[WIDTH-1:0];

        busy_d        = (state_d == INIT) || (state_d == ITER);
        product_we_d  = busy_d;
        result_rdy_d  = (state_d == DONE);
        product_res_d = abort && in_flight_c;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            q_prev_q      <= 1'b0;
            mcand_q       <= '0;
            load_q        <= '0;
            busy_q        <= 1'b0;
            result_rdy_q  <= 1'b0;
            product_we_q  <= 1'b0;
            product_res_q <= 1'b1;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            q_prev_q      <= q_prev_d;
            mcand_q       <= mcand_d;
            load_q        <= load_d;
            busy_q        <= busy_d;
            result_rdy_q  <= result_rdy_d;
            product_we_q  <= product_we_d;
            product_res_q <= product_res_d;
            result_q      <= result_d;
        end
    end

`ifdef MULT_OVF_CHECK_EN
    logic result_ovf_q, result_ovf_d;

    // Fits in WIDTH signed bits only if the top WIDTH+1 bits are all equal.
    always_comb begin
        result_ovf_d = result_ovf_q;
        if (state_d == DONE)
            result_ovf_d = ~(&booth_nxt[PW-1:WIDTH-1] | ~|booth_nxt[PW-1:WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (res) result_ovf_q <= 1'b0;
        else     result_ovf_q <= result_ovf_d;
    end

    assign result_ovf = result_ovf_q;
`else
    assign result_ovf = 1'b0;
`endif

    // Load value is held through INIT; the Booth step feeds the register during ITER.
    assign product_d   = (state_q == ITER) ? booth_nxt : load_q;
    assign product_we  = product_we_q;
    assign product_res = product_res_q;
    assign busy        = busy_q;
    assign result_rdy  = result_rdy_q;
    assign result      = result_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer with a behavioural product register.
module tb_mult_sequencer;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           res = 1'b1;
    logic           ctrl_mult = 1'b0;
    logic           abort = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic [2*W-1:0] product_q;
    logic [2*W-1:0] product_d;
    logic           product_we;
    logic           product_res;
    logic           busy;
    logic           result_rdy;
    logic [W-1:0]   result;
    logic           result_ovf;

    int pass_cnt = 0;
    int total = 0;

    localparam logic [W-1:0] VA [6] = '{32'd3, 32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF, 32'h00010000, 32'hFFFFFFFF};
    localparam logic [W-1:0] VB [6] = '{32'd4, 32'd6, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00010000, 32'hFFFFFFFF};
    localparam logic [W-1:0] VR [6] = '{32'd12, 32'hFFFFFFD6, 32'h80000000, 32'h00000001, 32'h00000000, 32'h00000001};
    localparam logic         VO [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    mult_sequencer dut (
        .clk         (clk),
        .res         (res),
        .ctrl_mult   (ctrl_mult),
        .abort       (abort),
        .op_a        (op_a),
        .op_b        (op_b),
        .product_q   (product_q),
        .product_d   (product_d),
        .product_we  (product_we),
        .product_res (product_res),
        .busy        (busy),
        .result_rdy  (result_rdy),
        .result      (result),
        .result_ovf  (result_ovf)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (product_res)     product_q <= '0;
        else if (product_we) product_q <= product_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        res = 1'b1;
        tick;
        tick;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (result_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", result_rdy); else pass_cnt++;
        total++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else pass_cnt++;
        total++; if (result_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", result_ovf); else pass_cnt++;
        total++; if (product_we !== 1'b0) $display("FAIL reset_we: got %b want 0", product_we); else pass_cnt++;
        total++; if (product_d !== 64'h0) $display("FAIL reset_pd: got %h want 0", product_d); else pass_cnt++;
        total++; if (product_res !== 1'b1) $display("FAIL reset_pres: got %b want 1", product_res); else pass_cnt++;
        res = 1'b0;
        tick;
        total++; if (product_res !== 1'b0) $display("FAIL reset_pres_release: got %b want 0", product_res); else pass_cnt++;
    endtask

    task automatic test_vectors;
        for (int i = 0; i < 6; i++) begin
            int  c;
            int  busy_n;
            logic exp_o;
`ifdef MULT_OVF_CHECK_EN
            exp_o = VO[i];
`else
            exp_o = 1'b0;
`endif
            op_a = VA[i];
            op_b = VB[i];
            ctrl_mult = 1'b1;
            tick;
            ctrl_mult = 1'b0;
            c = 1;
            busy_n = 0;
            while (!result_rdy && c < 100) begin
                if (busy) busy_n++;
                tick;
                c++;
            end
            total++; if (c !== 34) $display("FAIL vec%0d_latency: got %0d want 34", i, c); else pass_cnt++;
            total++; if (busy_n !== 33) $display("FAIL vec%0d_busy_cycles: got %0d want 33", i, busy_n); else pass_cnt++;
            total++; if (result !== VR[i]) $display("FAIL vec%0d_result: got %h want %h", i, result, VR[i]); else pass_cnt++;
            total++; if (result_ovf !== exp_o) $display("FAIL vec%0d_ovf: got %b want %b", i, result_ovf, exp_o); else pass_cnt++;
            total++; if (busy !== 1'b0) $display("FAIL vec%0d_busy_done: got %b want 0", i, busy); else pass_cnt++;
            total++; if (product_we !== 1'b0) $display("FAIL vec%0d_we_done: got %b want 0", i, product_we); else pass_cnt++;
            tick;
            total++; if (result_rdy !== 1'b0) $display("FAIL vec%0d_rdy_pulse: got %b want 0", i, result_rdy); else pass_cnt++;
            total++; if (result !== VR[i]) $display("FAIL vec%0d_result_hold: got %h want %h", i, result, VR[i]); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        int c;
        op_a = 32'd3;
        op_b = 32'd4;
        ctrl_mult = 1'b1;
        tick;
        ctrl_mult = 1'b0;
        c = 1;
        while (!result_rdy && c < 100) begin
            if (c == 10) begin
                ctrl_mult = 1'b1;
                op_a = 32'd5;
                op_b = 32'd5;
            end else begin
                ctrl_mult = 1'b0;
            end
            tick;
            c++;
        end
        total++; if (c !== 34) $display("FAIL b2b_first_latency: got %0d want 34", c); else pass_cnt++;
        total++; if (result !== 32'd12) $display("FAIL b2b_first_result: got %h want 0000000c", result); else pass_cnt++;
        op_a = 32'd100;
        op_b = 32'hFFFFFFFD;
        ctrl_mult = 1'b1;
        tick;
        ctrl_mult = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL b2b_start_in_done: got busy %b want 1", busy); else pass_cnt++;
        c = 1;
        while (!result_rdy && c < 100) begin
            tick;
            c++;
        end
        total++; if (c !== 34) $display("FAIL b2b_second_latency: got %0d want 34", c); else pass_cnt++;
        total++; if (result !== 32'hFFFFFED4) $display("FAIL b2b_second_result: got %h want fffffed4", result); else pass_cnt++;
        total++; if (result_ovf !== 1'b0) $display("FAIL b2b_second_ovf: got %b want 0", result_ovf); else pass_cnt++;
        tick;
    endtask

    task automatic test_abort;
        int c;
        int rdy_n;
        op_a = 32'd3;
        op_b = 32'd4;
        ctrl_mult = 1'b1;
        tick;
        ctrl_mult = 1'b0;
        c = 1;
        while (c < 12) begin
            tick;
            c++;
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (product_res !== 1'b1) $display("FAIL abort_pres: got %b want 1", product_res); else pass_cnt++;
        total++; if (result_rdy !== 1'b0) $display("FAIL abort_rdy: got %b want 0", result_rdy); else pass_cnt++;
        total++; if (result !== 32'hFFFFFED4) $display("FAIL abort_result_kept: got %h want fffffed4", result); else pass_cnt++;
        total++; if (product_we !== 1'b0) $display("FAIL abort_we: got %b want 0", product_we); else pass_cnt++;
        tick;
        total++; if (product_res !== 1'b0) $display("FAIL abort_pres_pulse: got %b want 0", product_res); else pass_cnt++;
        rdy_n = 0;
        for (int k = 0; k < 40; k++) begin
            if (result_rdy) rdy_n++;
            tick;
        end
        total++; if (rdy_n !== 0) $display("FAIL abort_no_rdy: got %0d pulses want 0", rdy_n); else pass_cnt++;
        abort = 1'b1;
        ctrl_mult = 1'b1;
        tick;
        abort = 1'b0;
        ctrl_mult = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_beats_start: got busy %b want 0", busy); else pass_cnt++;
        tick;
        total++; if (busy !== 1'b0) $display("FAIL abort_start_dropped: got busy %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_op;
        int c;
        op_a = 32'd3;
        op_b = 32'd4;
        ctrl_mult = 1'b1;
        tick;
        ctrl_mult = 1'b0;
        c = 1;
        while (c < 12) begin
            tick;
            c++;
        end
        res = 1'b1;
        tick;
        res = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL midres_busy: got %b want 0", busy); else pass_cnt++;
        total++; if (result_rdy !== 1'b0) $display("FAIL midres_rdy: got %b want 0", result_rdy); else pass_cnt++;
        total++; if (result !== 32'h0) $display("FAIL midres_result: got %h want 0", result); else pass_cnt++;
        total++; if (result_ovf !== 1'b0) $display("FAIL midres_ovf: got %b want 0", result_ovf); else pass_cnt++;
        total++; if (product_we !== 1'b0) $display("FAIL midres_we: got %b want 0", product_we); else pass_cnt++;
        total++; if (product_d !== 64'h0) $display("FAIL midres_pd: got %h want 0", product_d); else pass_cnt++;
        total++; if (product_res !== 1'b1) $display("FAIL midres_pres: got %b want 1", product_res); else pass_cnt++;
        tick;
        total++; if (product_res !== 1'b0) $display("FAIL midres_pres_release: got %b want 0", product_res); else pass_cnt++;
        op_a = 32'hFFFFFFF9;
        op_b = 32'd6;
        ctrl_mult = 1'b1;
        tick;
        ctrl_mult = 1'b0;
        c = 1;
        while (!result_rdy && c < 100) begin
            tick;
            c++;
        end
        total++; if (c !== 34) $display("FAIL midres_after_latency: got %0d want 34", c); else pass_cnt++;
        total++; if (result !== 32'hFFFFFFD6) $display("FAIL midres_after_result: got %h want ffffffd6", result); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_back_to_back;
        test_abort;
        test_reset_mid_op;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
